quadrant_decoder: RTL and testbench

Inverse of the quadrant encoder: accepts one WIDTH-bit cell-map slice tagged with a 2-bit quadrant id and steers it back into one of four quadrant buses (A..D). Writes land in shadow registers. The four output buses update together on a frame commit, so the downstream ant-farm state never shows a half-written frame. The block sits between the cell-update engine, which emits one quadrant slice at a time, and the quadrant storage/display path.

---
 rtl/quadrant_pkg.sv | 19 +
 rtl/quadrant_if.sv | 29 ++
 rtl/quadrant_bank.sv | 30 +++
 rtl/quadrant_decoder.sv | 77 +++++++
 tb/tb_quadrant_decoder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/quadrant_pkg.sv
// Shared constants and types for the quadrant encoder/decoder pair.
package quadrant_pkg;

  localparam logic [1:0] QUAD_A = 2'd0;
  localparam logic [1:0] QUAD_B = 2'd1;
  localparam logic [1:0] QUAD_C = 2'd2;
  localparam logic [1:0] QUAD_D = 2'd3;

  localparam int QUAD_WIDTH  = 105;
  localparam int FRAME_CNT_W = 8;

  // Decoder frame FSM: IDLE (nothing dirty), FILL (collecting), COMMIT (copy cycle).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/quadrant_if.sv
// Write/commit bus into the decoder and the committed quadrant outputs back out.
interface quadrant_if
  import quadrant_pkg::*;
#(
  parameter int WIDTH = QUAD_WIDTH
);
  logic                   wr_en;
  logic [1:0]             wr_quadrant;
  logic [WIDTH-1:0]       wr_data;
  logic                   commit;
  logic [WIDTH-1:0]       outA;
  logic [WIDTH-1:0]       outB;
  logic [WIDTH-1:0]       outC;
  logic [WIDTH-1:0]       outD;
  logic [3:0]             dirty;
  logic                   frame_valid;
  logic                   overwrite_err;
  logic [FRAME_CNT_W-1:0] frame_count;

  modport master (
    output wr_en, wr_quadrant, wr_data, commit,
    input  outA, outB, outC, outD, dirty, frame_valid, overwrite_err, frame_count
  );

  modport slave (
    input  wr_en, wr_quadrant, wr_data, commit,
    output outA, outB, outC, outD, dirty, frame_valid, overwrite_err, frame_count
  );
endinterface

// File: rtl/quadrant_bank.sv
// One quadrant: a shadow register written by the update engine and a
// committed register that only follows the shadow on a frame copy.
module quadrant_bank
  import quadrant_pkg::*;
#(
  parameter int WIDTH = QUAD_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             load,
  input  logic             copy,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] committed
);
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] committed_q;

  // Shadow takes new data on load; committed samples the pre-load shadow on copy.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      shadow_q    <= '0;
      committed_q <= '0;
    end else begin
      if (load) shadow_q <= data;
      if (copy) committed_q <= shadow_q;
    end
  end

  assign committed = committed_q;
endmodule

// File: rtl/quadrant_decoder.sv
// Steers tagged quadrant slices into shadow banks and publishes all dirty
// quadrants together on a frame commit.
module quadrant_decoder
  import quadrant_pkg::*;
(
  input  logic     clk_in,
  input  logic     rst,
  quadrant_if.slave bus
);
  state_t                 state_q, state_d;
  logic [3:0]             dirty_q, dirty_d;
  logic                   err_q, err_d;
  logic                   frame_valid_q;
  logic [FRAME_CNT_W-1:0] frame_count_q;
  logic [3:0]             wr_onehot;
  logic                   copy_en;
  logic [QUAD_WIDTH-1:0]  out_w [4];

  // Decode the write target and derive next dirty mask / overwrite error.
  // In COMMIT the mask is cleared first, so a write there starts the next frame.
  always_comb begin
    wr_onehot = 4'b0000;
    if (bus.wr_en) wr_onehot = 4'b0001 << bus.wr_quadrant;
    copy_en = (state_q == COMMIT);
    dirty_d = (copy_en ? 4'b0000 : dirty_q) | wr_onehot;
    err_d   = !copy_en && ((dirty_q & wr_onehot) != 4'b0000);
  end

  // Next-state logic: commit on a full mask or an explicit request while filling.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.wr_en) state_d = FILL;
      FILL:    if ((dirty_d == 4'b1111) || bus.commit) state_d = COMMIT;
      COMMIT:  state_d = bus.wr_en ? FILL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, dirty mask, pulses and frame counter registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      dirty_q       <= 4'b0000;
      err_q         <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      dirty_q       <= dirty_d;
      err_q         <= err_d;
      frame_valid_q <= copy_en;
      if (copy_en) frame_count_q <= frame_count_q + FRAME_CNT_W'(1);
    end
  end

  // Only quadrants dirty in the committing frame are copied; others hold.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    quadrant_bank #(.WIDTH(QUAD_WIDTH)) u_bank (
      .clk_in    (clk_in),
      .rst       (rst),
      .load      (wr_onehot[gi]),
      .copy      (copy_en && dirty_q[gi]),
      .data      (bus.wr_data),
      .committed (out_w[gi])
    );
  end

  assign bus.outA          = out_w[QUAD_A];
  assign bus.outB          = out_w[QUAD_B];
  assign bus.outC          = out_w[QUAD_C];
  assign bus.outD          = out_w[QUAD_D];
  assign bus.dirty         = dirty_q;
  assign bus.frame_valid   = frame_valid_q;
  assign bus.overwrite_err = err_q;
  assign bus.frame_count   = frame_count_q;
endmodule

// File: tb/tb_quadrant_decoder.sv
// Directed bench for quadrant_decoder with a transaction-level reference model.
module tb_quadrant_decoder;
  import quadrant_pkg::*;

  localparam int W = QUAD_WIDTH;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  quadrant_if #(.WIDTH(W)) bus ();

  quadrant_decoder dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: frame-level view of shadows, published buses and pulses.
  bit [W-1:0] m_shadow [4];
  bit [W-1:0] m_out    [4];
  bit [3:0]   m_dirty;
  bit         m_in_commit;
  bit         m_fv;
  bit         m_err;
  int         m_count;
  bit [3:0]   m_before;
  bit         m_was_commit;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each edge, then compare all outputs just after it.
  always @(posedge clk_in) begin
    if (rst) begin
      for (int q = 0; q < 4; q++) begin
        m_shadow[q] = '0;
        m_out[q]    = '0;
      end
      m_dirty = 0; m_in_commit = 0; m_fv = 0; m_err = 0; m_count = 0;
    end else begin
      m_before     = m_dirty;
      m_was_commit = m_in_commit;
      m_fv         = m_was_commit;
      m_err        = 0;
      if (m_was_commit) begin
        for (int q = 0; q < 4; q++)
          if (m_dirty[q]) m_out[q] = m_shadow[q];
        m_dirty = 0;
        m_count = (m_count + 1) % 256;
      end
      if (bus.wr_en) begin
        if (m_dirty[bus.wr_quadrant]) m_err = 1;
        m_shadow[bus.wr_quadrant] = bus.wr_data;
        m_dirty[bus.wr_quadrant]  = 1'b1;
      end
      m_in_commit = !m_was_commit && (m_before != 0) && ((m_dirty == 4'hF) || bus.commit);
    end
    #1;
    chk("outA", bus.outA, m_out[0]);
    chk("outB", bus.outB, m_out[1]);
    chk("outC", bus.outC, m_out[2]);
    chk("outD", bus.outD, m_out[3]);
    chk("dirty", W'(bus.dirty), W'(m_dirty));
    chk("frame_valid", W'(bus.frame_valid), W'(m_fv));
    chk("overwrite_err", W'(bus.overwrite_err), W'(m_err));
    chk("frame_count", W'(bus.frame_count), W'(m_count));
  end

  // One bus transaction: drive at the falling edge, return just after the rising edge.
  task automatic cyc(input bit wr, input bit [1:0] q, input logic [W-1:0] d, input bit cm);
    @(negedge clk_in);
    bus.wr_en = wr; bus.wr_quadrant = q; bus.wr_data = d; bus.commit = cm;
    @(posedge clk_in);
    #2;
    $display("txn t=%0t wr=%0b q=%0d data=%0h commit=%0b -> dirty=%b fv=%0b err=%0b cnt=%0d",
             $time, wr, q, d, cm, bus.dirty, bus.frame_valid, bus.overwrite_err, bus.frame_count);
  endtask

  task automatic full_frame(input logic [W-1:0] base);
    for (int q = 0; q < 4; q++) cyc(1'b1, 2'(q), base + W'(q), 1'b0);
    cyc(1'b0, 2'd0, '0, 1'b0);
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_quadrant = 0; bus.wr_data = '0; bus.commit = 0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    #1;
    chk("rst_outA", bus.outA, W'(0));
    chk("rst_count", W'(bus.frame_count), W'(0));
    chk("rst_dirty", W'(bus.dirty), W'(0));

    // First frame: four consecutive writes, auto-commit.
    cyc(1, 2'd0, W'('h1), 0);
    cyc(1, 2'd1, W'('h2), 0);
    cyc(1, 2'd2, W'('h3), 0);
    chk("f1_outA_hold", bus.outA, W'(0));
    cyc(1, 2'd3, W'('h4), 0);
    chk("f1_outD_hold", bus.outD, W'(0));
    chk("f1_fv_early", W'(bus.frame_valid), W'(0));
    cyc(0, 2'd0, '0, 0);
    chk("f1_outA", bus.outA, W'('h1));
    chk("f1_outB", bus.outB, W'('h2));
    chk("f1_outC", bus.outC, W'('h3));
    chk("f1_outD", bus.outD, W'('h4));
    chk("f1_fv", W'(bus.frame_valid), W'(1));
    chk("f1_count", W'(bus.frame_count), W'(1));
    chk("f1_dirty", W'(bus.dirty), W'(0));
    cyc(0, 2'd0, '0, 0);
    chk("f1_fv_drop", W'(bus.frame_valid), W'(0));

    // Partial frame with explicit commit.
    cyc(1, 2'd1, W'('hAA), 0);
    cyc(0, 2'd0, '0, 1);
    cyc(0, 2'd0, '0, 0);
    chk("f2_outB", bus.outB, W'('hAA));
    chk("f2_outA", bus.outA, W'('h1));
    chk("f2_fv", W'(bus.frame_valid), W'(1));
    chk("f2_dirty", W'(bus.dirty), W'(0));

    // Overwrite of a dirty quadrant.
    cyc(1, 2'd2, W'('h5), 0);
    cyc(1, 2'd2, W'('h6), 0);
    chk("f3_err", W'(bus.overwrite_err), W'(1));
    cyc(0, 2'd0, '0, 1);
    chk("f3_err_pulse", W'(bus.overwrite_err), W'(0));
    cyc(0, 2'd0, '0, 0);
    chk("f3_outC", bus.outC, W'('h6));
    chk("f3_count", W'(bus.frame_count), W'(3));

    // Write during the COMMIT cycle belongs to the next frame.
    for (int q = 0; q < 4; q++) cyc(1, 2'(q), W'('h10 + q), 0);
    cyc(1, 2'd0, W'('hBEEF), 0);
    chk("f4_outA_old", bus.outA, W'('h10));
    chk("f4_dirty", W'(bus.dirty), W'(1));
    chk("f4_err", W'(bus.overwrite_err), W'(0));
    cyc(0, 2'd0, '0, 0);
    chk("f4_err_after", W'(bus.overwrite_err), W'(0));
    cyc(0, 2'd0, '0, 1);
    cyc(0, 2'd0, '0, 0);
    chk("f5_outA", bus.outA, W'('hBEEF));
    chk("f5_count", W'(bus.frame_count), W'(5));

    // Commit while idle is ignored.
    cyc(0, 2'd0, '0, 1);
    cyc(0, 2'd0, '0, 0);
    chk("idle_commit_fv", W'(bus.frame_valid), W'(0));
    chk("idle_commit_cnt", W'(bus.frame_count), W'(5));

    // 256 frames: counter wraps through 0 and returns to 5.
    for (int i = 0; i < 256; i++) begin
      full_frame(W'(i * 16));
      if (i == 250) chk("wrap_zero", W'(bus.frame_count), W'(0));
    end
    chk("wrap_256", W'(bus.frame_count), W'(5));
    chk("wrap_outD", bus.outD, W'(255 * 16 + 3));

    // Asynchronous reset mid-frame.
    cyc(1, 2'd0, W'('h77), 0);
    cyc(1, 2'd1, W'('h88), 0);
    chk("pre_rst_dirty", W'(bus.dirty), W'(3));
    bus.wr_en = 0; bus.commit = 0;
    rst = 1'b1;
    #1;
    chk("arst_outA", bus.outA, W'(0));
    chk("arst_outB", bus.outB, W'(0));
    chk("arst_outD", bus.outD, W'(0));
    chk("arst_dirty", W'(bus.dirty), W'(0));
    chk("arst_count", W'(bus.frame_count), W'(0));
    @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;

    // First frame after reset.
    full_frame(W'('h21));
    chk("post_outA", bus.outA, W'('h21));
    chk("post_outD", bus.outD, W'('h24));
    chk("post_count", W'(bus.frame_count), W'(1));
    cyc(0, 2'd0, '0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
